// File: rtl/ftdi_tx_stream_arbiter.sv
// ftdi_tx_stream_arbiter: packet-atomic round-robin mux of N AXI-streams onto the FTDI TX stream
module ftdi_tx_stream_arbiter #(
    parameter int         N         = 4,
    parameter int         EW        = 2,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic [N-1:0]           s_tvalid,
    output logic [N-1:0]           s_tready,
    input  logic [N*(8<<EW)-1:0]   s_tdata,
    input  logic [N*(1<<EW)-1:0]   s_tkeep,
    input  logic [N-1:0]           s_tlast,
    input  logic                   m_tready,
    output logic                   m_tvalid,
    output logic [(8<<EW)-1:0]     m_tdata,
    output logic [(1<<EW)-1:0]     m_tkeep,
    output logic                   m_tlast,
    output logic [3:0]             grant_id,
    output logic                   busy
);
    localparam int DW = 8 << EW;
    localparam int KW = 1 << EW;
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q, ptr_q, pick_d, idx;
    logic            found;
    logic            m_tvalid_q, m_tlast_q;
    logic [DW-1:0]   m_tdata_q;
    logic [KW-1:0]   m_tkeep_q;
    logic            can_load, take;
    logic [DW-1:0]   hdr_word;

    assign can_load = !m_tvalid_q || m_tready;
    assign take     = state_q == DATA && can_load && s_tvalid[grant_q];
    assign hdr_word = DW'({HDR_MAGIC, 8'(grant_q)}) << (DW - 16);
    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign grant_id = 4'(grant_q);
    assign busy     = state_q != IDLE;

    // first valid requester at or after the pointer, wrapping
    always_comb begin
        pick_d = ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(ptr_q) + k) % N);
            if (!found && s_tvalid[idx]) begin
                found  = 1'b1;
                pick_d = idx;
            end
        end
    end

    // only the granted requester sees ready, and only while a beat can be stored
    always_comb begin
        s_tready          = '0;
        s_tready[grant_q] = state_q == DATA && can_load;
    end

    // arbitration FSM and the single output register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            if (m_tready) m_tvalid_q <= 1'b0;
            case (state_q)
                IDLE: if (found) begin
                    grant_q <= pick_d;
                    state_q <= HDR_EN ? HDR : DATA;
                end
                HDR: if (can_load) begin
                    m_tvalid_q <= 1'b1;
                    m_tdata_q  <= hdr_word;
                    m_tkeep_q  <= '1;
                    m_tlast_q  <= 1'b0;
                    state_q    <= DATA;
                end
                DATA: if (take) begin
                    m_tvalid_q <= 1'b1;
                    m_tdata_q  <= s_tdata[grant_q*DW +: DW];
                    m_tkeep_q  <= s_tkeep[grant_q*KW +: KW];
                    m_tlast_q  <= s_tlast[grant_q];
                    if (s_tlast[grant_q]) begin
                        ptr_q   <= grant_q == GW'(N - 1) ? '0 : grant_q + GW'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ftdi_tx_stream_arbiter.sv
// tb_ftdi_tx_stream_arbiter: scoreboard bench for the TX stream arbiter
module tb_ftdi_tx_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] rd[N];
    logic [KW-1:0] rk[N];
    logic          rv[N], rl[N];
    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic            m_tready, m_tvalid, m_tlast, busy;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [3:0]      grant_id;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_tvalid[g]            = rv[g];
        assign s_tlast[g]             = rl[g];
        assign s_tdata[g*DW +: DW]    = rd[g];
        assign s_tkeep[g*KW +: KW]    = rk[g];
    end

    ftdi_tx_stream_arbiter #(.N(N), .EW(2), .HDR_EN(1'b1), .HDR_MAGIC(8'hA5)) u_dut (
        .clk(clk), .rst_async(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy)
    );

    logic [3:0]      b_vld, b_rdy, b_last;
    logic [127:0]    b_data;
    logic [15:0]     b_keep;
    logic            b_mrdy, b_mvld, b_mlast, b_busy;
    logic [31:0]     b_mdata;
    logic [3:0]      b_mkeep, b_grant;

    ftdi_tx_stream_arbiter #(.N(N), .EW(2), .HDR_EN(1'b0), .HDR_MAGIC(8'hA5)) u_dut_nohdr (
        .clk(clk), .rst_async(rst),
        .s_tvalid(b_vld), .s_tready(b_rdy), .s_tdata(b_data), .s_tkeep(b_keep), .s_tlast(b_last),
        .m_tready(b_mrdy), .m_tvalid(b_mvld), .m_tdata(b_mdata), .m_tkeep(b_mkeep), .m_tlast(b_mlast),
        .grant_id(b_grant), .busy(b_busy)
    );

    int    tests = 0;
    int    fails = 0;
    beat_t qa[$];
    beat_t qb[$];
    logic  mon_en = 1'b1;
    logic  abort  = 1'b0;
    logic  tog    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor for the header-enabled instance: in-order compare plus hold-under-stall check
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) chk("stall_stable", {m_tdata, m_tkeep, m_tlast}, prev_beat);
            if (m_tvalid && m_tready) begin
                if (qa.size() == 0) chk("unexpected_beat", {m_tdata, m_tkeep, m_tlast}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("beat", {m_tdata, m_tkeep, m_tlast}, qa.pop_front());
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tdata, m_tkeep, m_tlast};
        end else prev_stall = 1'b0;
    end

    // monitor for the header-less instance
    always @(negedge clk) begin
        if (!rst && b_mvld && b_mrdy) begin
            if (qb.size() == 0) chk("b_unexpected_beat", {b_mdata, b_mkeep, b_mlast}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("b_beat", {b_mdata, b_mkeep, b_mlast}, qb.pop_front());
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_tready = tog ? ~m_tready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push_pkt(input int s, input int nb, input logic [31:0] base, input logic [31:0] step);
        qa.push_back({8'hA5, 8'(s), 16'h0000, 4'hF, 1'b0});
        for (int b = 0; b < nb; b++) qa.push_back({base + step * b, 4'hF, b == nb - 1});
    endtask

    task automatic send(input int s, input int nb, input logic [31:0] base, input logic [31:0] step,
                        input int gap_at, input int gap_len);
        int t;
        bit acc;
        for (int b = 0; b < nb && !abort; b++) begin
            if (b == gap_at) begin
                rv[s] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            rv[s] = 1'b1;
            rd[s] = base + step * b;
            rk[s] = 4'hF;
            rl[s] = b == nb - 1;
            t = 0;
            acc = 1'b0;
            while (!acc && !abort) begin
                @(negedge clk);
                acc = s_tready[s];
                @(posedge clk);
                #1;
                if (++t > 300) begin
                    chk("send_timeout", 64'(s), 64'hFF);
                    rv[s] = 1'b0;
                    return;
                end
            end
        end
        rv[s] = 1'b0;
        rl[s] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || busy) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", 64'(t >= 500), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; rl[i] = 1'b0; rd[i] = '0; rk[i] = '0;
        end
        b_vld = '0; b_last = '0; b_data = '0; b_keep = '0; b_mrdy = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_m_tdata",  64'(m_tdata),  64'h0);
        chk("rst_m_tkeep",  64'(m_tkeep),  64'h0);
        chk("rst_m_tlast",  64'(m_tlast),  64'h0);
        chk("rst_s_tready", 64'(s_tready), 64'h0);
        chk("rst_grant_id", 64'(grant_id), 64'h0);
        chk("rst_busy",     64'(busy),     64'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single requester 2, three beats
        push_pkt(2, 3, 32'h1111_1111, 32'h1111_1111);
        send(2, 3, 32'h1111_1111, 32'h1111_1111, -1, 0);
        chk("t1_busy_after_last", 64'(busy), 64'h0);
        chk("t1_grant_id", 64'(grant_id), 64'h2);
        drain();

        // pointer back to 0, then all four requesters continuously valid
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) push_pkt(s, 2, 32'hCAFE_0000 + 32'(s * 256 + p * 16), 32'h1);
        fork
            begin send(0, 2, 32'hCAFE_0000, 1, -1, 0); send(0, 2, 32'hCAFE_0010, 1, -1, 0); end
            begin send(1, 2, 32'hCAFE_0100, 1, -1, 0); send(1, 2, 32'hCAFE_0110, 1, -1, 0); end
            begin send(2, 2, 32'hCAFE_0200, 1, -1, 0); send(2, 2, 32'hCAFE_0210, 1, -1, 0); end
            begin send(3, 2, 32'hCAFE_0300, 1, -1, 0); send(3, 2, 32'hCAFE_0310, 1, -1, 0); end
        join
        drain();
        chk("t2_grant_id", 64'(grant_id), 64'h3);

        // backpressure on a 4-beat packet from requester 1
        tog = 1'b1;
        push_pkt(1, 4, 32'hB0B0_0000, 32'h0101_0101);
        send(1, 4, 32'hB0B0_0000, 32'h0101_0101, -1, 0);
        drain();
        tog = 1'b0;

        // requester 1 stalls mid-packet while requester 3 waits
        push_pkt(1, 4, 32'h4141_0000, 32'h1);
        push_pkt(3, 2, 32'h4343_0000, 32'h1);
        fork
            send(1, 4, 32'h4141_0000, 32'h1, 2, 5);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(3, 2, 32'h4343_0000, 32'h1, -1, 0);
            end
        join
        drain();

        // header-less instance, single sparse-keep beat
        qb.push_back({32'hDEAD_BEEF, 4'b0011, 1'b1});
        b_vld = 4'b0001; b_data[31:0] = 32'hDEAD_BEEF; b_keep[3:0] = 4'b0011; b_last = 4'b0001;
        begin
            int t = 0;
            bit acc = 1'b0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = b_rdy[0];
                @(posedge clk);
                #1;
                t++;
            end
            chk("b_accept_timeout", 64'(acc), 64'h1);
        end
        b_vld = '0; b_last = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("b_queue_empty", 64'(qb.size()), 64'h0);
        chk("b_grant_id", 64'(b_grant), 64'h0);

        // reset mid-packet: pointer must come back to 0
        push_pkt(2, 1, 32'h2222_0000, 32'h1);
        send(2, 1, 32'h2222_0000, 32'h1, -1, 0);
        drain();
        mon_en = 1'b0;
        fork
            send(3, 8, 32'h3333_0000, 32'h1, -1, 0);
        join_none
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("mid_rst_m_tdata",  64'(m_tdata),  64'h0);
        chk("mid_rst_m_tkeep",  64'(m_tkeep),  64'h0);
        chk("mid_rst_m_tlast",  64'(m_tlast),  64'h0);
        chk("mid_rst_s_tready", 64'(s_tready), 64'h0);
        chk("mid_rst_grant_id", 64'(grant_id), 64'h0);
        chk("mid_rst_busy",     64'(busy),     64'h0);
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        qa.delete();
        rst = 1'b0;
        abort = 1'b0;
        mon_en = 1'b1;
        push_pkt(0, 1, 32'h00AA_0000, 32'h1);
        push_pkt(3, 1, 32'h33AA_0000, 32'h1);
        fork
            send(0, 1, 32'h00AA_0000, 32'h1, -1, 0);
            send(3, 1, 32'h33AA_0000, 32'h1, -1, 0);
        join
        drain();
        chk("t6_grant_id", 64'(grant_id), 64'h3);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_empty", 64'(qa.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ftdi_tx_stream_arbiter.md
Name: ftdi_tx_stream_arbiter

Overview:
- Shares the single TX AXI-stream input of the FTDI 245-fifo controller among N independent requesters.
- Grants one requester at a time, packet-atomically: the grant is held until that requester's tlast beat.
- Grants rotate round-robin across requesters.
- Optionally prepends a one-beat header carrying the source index, so the host can demultiplex. Sits between user logic and the controller's tx_* port in the tx_clk domain.

Parameters:
- N, 4, number of requesters (2..16).
- EW, 2, stream width exponent: data = 8<<EW bits, keep = 1<<EW bits. EW must be ≥ 1.
- HDR_EN, 1, 1 = emit header beat before each packet; 0 = no header.
- HDR_MAGIC, 8'hA5, top byte of the header word.

Ports:
- clk  in  1  stream clock (same as controller tx_clk).
- rst_async  in  1  asynchronous reset, active-high.
- s_tvalid  in  N  per-requester valid.
- s_tready  out  N  per-requester ready.
- s_tdata  in  N*(8<<EW)  requester i occupies slice i.
- s_tkeep  in  N*(1<<EW)  per-requester keep.
- s_tlast  in  N  per-requester last.
- m_tready  in  1  from controller tx_tready.
- m_tvalid  out  1  to controller.
- m_tdata  out  8<<EW  to controller.
- m_tkeep  out  1<<EW  to controller.
- m_tlast  out  1  to controller.
- grant_id  out  4  index of current/last granted requester.
- busy  out  1  1 while a packet is in flight (state ≠ IDLE).

Behaviour:
- Reset (async assert, clk-sync release) forces state = IDLE.
- Reset values of all outputs are 0: m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, grant_id, busy. Round-robin pointer resets to 0.
- Output stage is a single register:
  - m_* update only when the register is empty (m_tvalid = 0) or m_tready = 1.
  - Throughput is 1 beat/cycle when m_tready is held high.
  - m_tvalid, once set, stays high and m_* stay stable until m_tready.
- States: IDLE, HDR, DATA.
- IDLE: arbitration.
  - If any s_tvalid = 1, pick the first requester at or after the pointer (wrapping from N-1 to 0) with s_tvalid = 1.
  - Latch its index into grant_id.
  - Go to HDR if HDR_EN = 1, else go to DATA.
  - The arbitration cycle produces no output beat.
  - All s_tready are 0 in IDLE.
- HDR:
  - When the output register can load, load the header word: m_tdata = {HDR_MAGIC, 8'(grant_id), zero pad}, m_tkeep = all ones, m_tlast = 0, m_tvalid = 1. Then go to DATA.
- DATA:
  - s_tready[grant_id] = (!m_tvalid || m_tready). All other s_tready are 0.
  - On s_tvalid & s_tready of the granted requester, copy tdata, tkeep and tlast into the output register.
  - When the accepted beat has tlast = 1: set pointer = grant_id+1 (mod N) and go to IDLE. The next arbitration starts the following cycle.
- Fairness: a requester that is continuously valid waits at most N-1 packets.
- Simultaneous requests are resolved solely by the pointer. A single requester that is continuously valid gets back-to-back packets, with one idle cycle between packets for arbitration.
- Valid drops from the granted requester mid-packet: the grant is held with no timeout; other requesters wait.
- Requests from non-granted requesters are ignored until IDLE.
- tkeep passes through unchanged (sparse keep is allowed); tkeep = 0 beats are forwarded as-is.
- grant_id holds its last value in IDLE.
- Reset mid-packet: in-flight beats are discarded and the pointer returns to 0. Requesters must restart their packets.

Test Plan:
- Reset, HDR_EN = 1, only requester 2 sends 3 beats (0x11111111, 0x22222222, 0x33333333 with last), m_tready = 1.
  → m_ carries 0xA5020000 (last = 0), then the 3 beats with last on the third; grant_id = 2; busy drops after the last.
- All 4 requesters continuously valid, each sending 2-beat packets.
  → headers appear in source order 0, 1, 2, 3, 0, 1, …; no source is granted twice before all others.
- Backpressure: m_tready toggles 1010… during a 4-beat packet.
  → no beat is lost or duplicated; m_tdata is stable while m_tvalid & !m_tready.
- Granted requester 1 drops tvalid for 5 cycles mid-packet while requester 3 is valid.
  → no beat from 3 is emitted until 1's tlast; then the header for 3 is emitted.
- HDR_EN = 0, requester 0 sends a single-beat packet (tdata 0xDEADBEEF, keep 4'b0011, last).
  → exactly one m_ beat: 0xDEADBEEF, keep 0011, last = 1.
- Assert rst_async during DATA, mid-packet.
  → all outputs go to 0 immediately; after release, arbitration restarts from requester 0.
